rx_spw_sync: RTL
================

# rx_spw_sync

Single-clock, oversampling SpaceWire receiver and the parametrised successor of the DS-clock-recovered receiver. It samples rx_din/rx_sin in the system clock domain, recovers bits from D/S transitions, decodes NULL, FCT, EOP/EEP, N-Char and time-code characters, and checks odd parity and escape errors. Decoded N-Chars go into a parametrised FIFO with a read handshake, and disconnect timeout is optional. It sits between the LVDS pads and the link-interface FSM / host buffer.

## Interface
- FIFO_DEPTH, 64: N-Char FIFO entries; power of two, 4..1024.
- SYNC_STAGES, 2: input synchroniser flops per line, 2..4.
- DISC_CYCLES, 85: idle clocks without a D/S edge before a disconnect is declared.
- posedge_clk  in  1  system clock. Line bit period must be ≥ 3 clocks.
- rx_reset  in  1  asynchronous, active-high reset.
- rx_din, rx_sin  in  1  raw DS data and strobe.
- rx_enable  in  1  receiver enable; low forces HUNT and clears rx_error.
- rx_got_bit  out  1  pulse per recovered bit.
- rx_got_null, rx_got_fct, rx_got_nchar, rx_got_time_code  out  1  one-clock pulses per decoded character.
- rx_error  out  1  sticky: parity, escape, overflow or disconnect.
- rx_err_cause  out  4  sticky flags {disc, ovf, esc, par}.
- rx_rd_en  in  1  FIFO pop request.
- rx_data_flag  out  9  FIFO head {flag, data}; show-ahead.
- rx_fifo_empty  out  1  FIFO empty.
- rx_fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- rx_time_out  out  8  last time-code, with control flags in [7:6].
- rx_tick_out  out  1  one-clock pulse with each time-code update.

## Operation
- Reset values: all pulses 0, rx_error 0, rx_err_cause 0, rx_data_flag 0, rx_fifo_empty 1, rx_fifo_count 0, rx_time_out 0, state HUNT.
- Bit recovery: after synchronisers, a change on din or sin in a clock produces one bit with value = synchronised din. Simultaneous din and sin change produces one bit.
- HUNT: shift each bit into a 7-bit window. Window {1,1,1,0,1,0,0} (oldest first) marks the first NULL: pulse rx_got_null and enter RUN. No parity check occurs before this point.
- RUN framing: bit0 is parity, bit1 is the flag.
  - Flag 1: two more bits c0,c1. 00=FCT, 01=EOP, 10=EEP, 11=ESC.
  - Flag 0: eight data bits, LSB first.
- Parity: the previous character's data/control bits plus the current parity and flag bits must have an odd count of ones. On failure set par, then enter ERROR.
- Escape handling:
  - ESC then FCT is a NULL: pulse rx_got_null, no FCT pulse.
  - ESC then N-Char is a time-code: latch rx_time_out, pulse rx_got_time_code and rx_tick_out.
  - ESC then ESC/EOP/EEP sets esc and enters ERROR.
- Normal characters:
  - Plain FCT pulses rx_got_fct.
  - Data pushes {0,d}. EOP pushes {1,8'h00}. EEP pushes {1,8'h01}. Each push pulses rx_got_nchar.
- FIFO:
  - A push when full is dropped and sets ovf, then enters ERROR.
  - Pop when empty is ignored.
  - Push and pop in the same clock are both honoured; count is unchanged, including when full.
- ERROR: decoding stops. FIFO stays readable. rx_error holds until rx_enable is low or reset.
- Reset or rx_enable low mid-character discards the partial character. The FIFO is flushed only by reset.

## Timing
- Pin edge to rx_got_bit: SYNC_STAGES+1 clocks.
- Final bit of a character to decode pulse: +1 clock.
- Push to rx_fifo_empty low and updated count: +1 clock.
- Pop: rx_data_flag shows the next entry one clock after rx_rd_en.
- Disconnect: edge counter reloads on each bit. After DISC_CYCLES clocks with no bit while in RUN, set disc and enter ERROR.

## Configuration
- RX_SPW_DISCONNECT_EN defined: disconnect counter present as above.
- Undefined: counter removed, disc tied 0, DISC_CYCLES ignored.

## Structure
- Package spw_rx_pkg:
  - control codes FCT/EOP/EEP/ESC;
  - EOP/EEP flag words;
  - state enum HUNT/RUN/ERROR;
  - error-cause bit indices.
- Sub-module rx_spw_sync_fifo: synchronous show-ahead FIFO with depth FIFO_DEPTH and width 9. Decoder and sampler stay in the top.

## Test plan
- NULL, then data 0x5A, then EOP at 4 clocks/bit. Expect rx_got_null, then FIFO entries 0x05A and 0x100, rx_fifo_count=2.
- NULL, then FCT, FCT. Expect two rx_got_fct pulses and no rx_got_nchar.
- NULL, then ESC+N-Char 0x47. Expect rx_time_out=0x47, one rx_tick_out pulse, FIFO untouched.
- Flip the parity bit of the second character. Expect rx_err_cause=4'b0001, rx_error=1, no further pulses until rx_enable toggles.
- Fill FIFO_DEPTH entries with no reads, then send one more data char. Expect count=FIFO_DEPTH, ovf set, and a simultaneous read/write at full leaves count unchanged.
- With RX_SPW_DISCONNECT_EN, hold lines static for DISC_CYCLES clocks after NULL. Expect disc set on the following clock; without the macro, no error.

Source files
------------

// File: rtl/spw_rx_pkg.sv
// Shared definitions for the rx_spw_sync SpaceWire receiver:
// control codes, FIFO flag words, decoder states and error-cause bit positions.
package spw_rx_pkg;

  // Control codes as {c0, c1}, where c0 is the first bit after the flag.
  localparam logic [1:0] CTRL_FCT = 2'b00;
  localparam logic [1:0] CTRL_EOP = 2'b01;
  localparam logic [1:0] CTRL_EEP = 2'b10;
  localparam logic [1:0] CTRL_ESC = 2'b11;

  localparam logic [8:0] FLAG_EOP = 9'h100;
  localparam logic [8:0] FLAG_EEP = 9'h101;

  // Last seven HUNT bits (oldest in the MSB) that form the first NULL.
  localparam logic [6:0] NULL_WINDOW = 7'b1110100;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } rx_state_t;

  localparam int ERR_PAR  = 0;
  localparam int ERR_ESC  = 1;
  localparam int ERR_OVF  = 2;
  localparam int ERR_DISC = 3;

endpackage

// File: rtl/rx_spw_sync_fifo.sv
// Synchronous show-ahead FIFO for decoded N-Chars; the head word is visible
// combinationally and reads as zero while the FIFO is empty.
module rx_spw_sync_fifo #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 9
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occupancy;
  logic             do_rd;
  logic             do_wr;

  // A write into a full FIFO is still taken when a pop frees the slot in the same clock.
  assign do_rd = rd_en && (occupancy != '0);
  assign do_wr = wr_en && (!full || do_rd);

  assign empty   = (occupancy == '0);
  assign full    = (occupancy == (AW+1)'(DEPTH));
  assign count   = occupancy;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule

// File: rtl/rx_spw_sync.sv
// Oversampling SpaceWire receiver: DS bit recovery, character decoding and N-Char FIFO.
// Define RX_SPW_DISCONNECT_EN to include the disconnect timeout (DISC_CYCLES).
module rx_spw_sync
  import spw_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 64,
  parameter int SYNC_STAGES = 2,
  parameter int DISC_CYCLES = 85
) (
  input  logic                          posedge_clk,
  input  logic                          rx_reset,
  input  logic                          rx_din,
  input  logic                          rx_sin,
  input  logic                          rx_enable,
  output logic                          rx_got_bit,
  output logic                          rx_got_null,
  output logic                          rx_got_fct,
  output logic                          rx_got_nchar,
  output logic                          rx_got_time_code,
  output logic                          rx_error,
  output logic [3:0]                    rx_err_cause,
  input  logic                          rx_rd_en,
  output logic [8:0]                    rx_data_flag,
  output logic                          rx_fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count,
  output logic [7:0]                    rx_time_out,
  output logic                          rx_tick_out
);

  logic [SYNC_STAGES-1:0] din_sync;
  logic [SYNC_STAGES-1:0] sin_sync;
  logic                   din_prev;
  logic                   sin_prev;
  logic                   bit_val;

  rx_state_t   state, state_n;
  logic [5:0]  win, win_n;
  logic [3:0]  cnt, cnt_n;
  logic [6:0]  shift, shift_n;
  logic        par_bit, par_bit_n;
  logic        flag, flag_n;
  logic        prev_par, prev_par_n;
  logic        run_par, run_par_n;
  logic        esc_pend, esc_pend_n;
  logic [3:0]  err_cause, err_cause_n;
  logic [7:0]  time_q, time_n;
  logic        null_q, null_n;
  logic        fct_q, fct_n;
  logic        tc_q, tc_n;
  logic        push_q, push_n;
  logic [8:0]  push_data, push_data_n;

  logic [1:0]  ctrl_code;
  logic [7:0]  data_byte;
  logic        fifo_full;
  logic        ovf_evt;
  logic        disc_evt;

  // A bit is any change on D or S after synchronisation; its value is the synchronised D.
  always_ff @(posedge posedge_clk or posedge rx_reset) begin
    if (rx_reset) begin
      din_sync   <= '0;
      sin_sync   <= '0;
      din_prev   <= 1'b0;
      sin_prev   <= 1'b0;
      rx_got_bit <= 1'b0;
      bit_val    <= 1'b0;
    end else begin
      din_sync   <= {din_sync[SYNC_STAGES-2:0], rx_din};
      sin_sync   <= {sin_sync[SYNC_STAGES-2:0], rx_sin};
      din_prev   <= din_sync[SYNC_STAGES-1];
      sin_prev   <= sin_sync[SYNC_STAGES-1];
      rx_got_bit <= (din_sync[SYNC_STAGES-1] ^ din_prev) |
                    (sin_sync[SYNC_STAGES-1] ^ sin_prev);
      bit_val    <= din_sync[SYNC_STAGES-1];
    end
  end

  assign ctrl_code = {shift[6], bit_val};
  assign data_byte = {bit_val, shift};

`ifdef RX_SPW_DISCONNECT_EN
  localparam int DISC_W = $clog2(DISC_CYCLES + 1);
  logic [DISC_W-1:0] idle_cnt;

  always_ff @(posedge posedge_clk or posedge rx_reset) begin
    if (rx_reset) begin
      idle_cnt <= '0;
    end else if (rx_got_bit || (state != RUN)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign disc_evt = (state == RUN) && rx_enable && !rx_got_bit &&
                    (idle_cnt == DISC_W'(DISC_CYCLES - 1));
`else
  assign disc_evt = 1'b0;
`endif

  assign ovf_evt = push_q && fifo_full && !rx_rd_en && rx_enable;

  always_comb begin
    state_n     = state;
    win_n       = win;
    cnt_n       = cnt;
    shift_n     = shift;
    par_bit_n   = par_bit;
    flag_n      = flag;
    prev_par_n  = prev_par;
    run_par_n   = run_par;
    esc_pend_n  = esc_pend;
    err_cause_n = err_cause;
    time_n      = time_q;
    null_n      = 1'b0;
    fct_n       = 1'b0;
    tc_n        = 1'b0;
    push_n      = 1'b0;
    push_data_n = push_data;

    if (!rx_enable) begin
      state_n     = HUNT;
      win_n       = '0;
      cnt_n       = '0;
      esc_pend_n  = 1'b0;
      err_cause_n = '0;
    end else begin
      case (state)
        HUNT: begin
          if (rx_got_bit) begin
            win_n = {win[4:0], bit_val};
            if ({win, bit_val} == NULL_WINDOW) begin
              // The NULL just seen ends in an FCT, whose control bits are both zero.
              null_n     = 1'b1;
              state_n    = RUN;
              cnt_n      = '0;
              prev_par_n = 1'b0;
              esc_pend_n = 1'b0;
            end
          end
        end
        RUN: begin
          if (rx_got_bit) begin
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd0) begin
              par_bit_n = bit_val;
            end else if (cnt == 4'd1) begin
              if (!(prev_par ^ par_bit ^ bit_val)) begin
                err_cause_n[ERR_PAR] = 1'b1;
                state_n              = ERROR;
              end
              flag_n    = bit_val;
              run_par_n = 1'b0;
            end else begin
              run_par_n = run_par ^ bit_val;
              shift_n   = {bit_val, shift[6:1]};
              if (flag && (cnt == 4'd3)) begin
                cnt_n      = '0;
                prev_par_n = run_par ^ bit_val;
                if (esc_pend) begin
                  esc_pend_n = 1'b0;
                  if (ctrl_code == CTRL_FCT) begin
                    null_n = 1'b1;
                  end else begin
                    err_cause_n[ERR_ESC] = 1'b1;
                    state_n              = ERROR;
                  end
                end else begin
                  case (ctrl_code)
                    CTRL_FCT: fct_n = 1'b1;
                    CTRL_EOP: begin
                      push_n      = 1'b1;
                      push_data_n = FLAG_EOP;
                    end
                    CTRL_EEP: begin
                      push_n      = 1'b1;
                      push_data_n = FLAG_EEP;
                    end
                    default:  esc_pend_n = 1'b1;
                  endcase
                end
              end else if (!flag && (cnt == 4'd9)) begin
                cnt_n      = '0;
                prev_par_n = run_par ^ bit_val;
                if (esc_pend) begin
                  esc_pend_n = 1'b0;
                  time_n     = data_byte;
                  tc_n       = 1'b1;
                end else begin
                  push_n      = 1'b1;
                  push_data_n = {1'b0, data_byte};
                end
              end
            end
          end
        end
        default: begin
        end
      endcase

      // Overflow and disconnect take precedence over anything decoded in the same clock.
      if (ovf_evt) begin
        err_cause_n[ERR_OVF] = 1'b1;
      end
      if (disc_evt) begin
        err_cause_n[ERR_DISC] = 1'b1;
      end
      if (ovf_evt || disc_evt) begin
        state_n = ERROR;
        null_n  = 1'b0;
        fct_n   = 1'b0;
        tc_n    = 1'b0;
        push_n  = 1'b0;
      end
    end
  end

  always_ff @(posedge posedge_clk or posedge rx_reset) begin
    if (rx_reset) begin
      state     <= HUNT;
      win       <= '0;
      cnt       <= '0;
      shift     <= '0;
      par_bit   <= 1'b0;
      flag      <= 1'b0;
      prev_par  <= 1'b0;
      run_par   <= 1'b0;
      esc_pend  <= 1'b0;
      err_cause <= '0;
      time_q    <= '0;
      null_q    <= 1'b0;
      fct_q     <= 1'b0;
      tc_q      <= 1'b0;
      push_q    <= 1'b0;
      push_data <= '0;
    end else begin
      state     <= state_n;
      win       <= win_n;
      cnt       <= cnt_n;
      shift     <= shift_n;
      par_bit   <= par_bit_n;
      flag      <= flag_n;
      prev_par  <= prev_par_n;
      run_par   <= run_par_n;
      esc_pend  <= esc_pend_n;
      err_cause <= err_cause_n;
      time_q    <= time_n;
      null_q    <= null_n;
      fct_q     <= fct_n;
      tc_q      <= tc_n;
      push_q    <= push_n;
      push_data <= push_data_n;
    end
  end

  rx_spw_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clock   (posedge_clk),
    .reset   (rx_reset),
    .wr_en   (push_q),
    .wr_data (push_data),
    .rd_en   (rx_rd_en),
    .rd_data (rx_data_flag),
    .empty   (rx_fifo_empty),
    .full    (fifo_full),
    .count   (rx_fifo_count)
  );

  assign rx_got_null      = null_q;
  assign rx_got_fct       = fct_q;
  assign rx_got_nchar     = push_q;
  assign rx_got_time_code = tc_q;
  assign rx_tick_out      = tc_q;
  assign rx_time_out      = time_q;
  assign rx_err_cause     = err_cause;
  assign rx_error         = |err_cause;

endmodule
